dram_cell_ctrl: RTL

Initiator for the synchronous dual-port data RAM of the BF core. It drives that RAM's read port (rce/ra/rq) and write port (wce/wa/wd), and holds the data pointer. It executes one cell command at a time from the decoder: add to the current cell, move the pointer, read the cell, or write the cell. Read-modify-write sequencing and the RAM's one-cycle read latency are handled here, so the decoder sees a plain valid/ready command port and a valid/ready response port.

---
 rtl/dram_cell_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dram_cell_ctrl.sv
// Cell command controller for the BF core data RAM.
// Owns the data pointer and sequences ADD (read-modify-write), MOVE,
// READ and WRITE against a synchronous dual-port RAM with a one-cycle
// read latency. The decoder sees a valid/ready command port and a
// valid/ready response port that is used only by READ.
module dram_cell_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [D_WIDTH-1:0] cmd_arg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_data,
  output logic               rsp_zero,
  output logic [A_WIDTH-1:0] ptr,
  output logic               mem_rce,
  output logic [A_WIDTH-1:0] mem_ra,
  input  logic [D_WIDTH-1:0] mem_rq,
  output logic               mem_wce,
  output logic [A_WIDTH-1:0] mem_wa,
  output logic [D_WIDTH-1:0] mem_wd
);

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_MOVE  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_WRITE = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MOD  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [A_WIDTH-1:0] ptr_q, ptr_d;
  logic [D_WIDTH-1:0] arg_q, arg_d;
  logic               is_add_q, is_add_d;
  logic               rce_q, rce_d;
  logic [A_WIDTH-1:0] ra_q, ra_d;
  logic               wce_q, wce_d;
  logic [A_WIDTH-1:0] wa_q, wa_d;
  logic [D_WIDTH-1:0] wd_q, wd_d;
  logic               rv_q, rv_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic [A_WIDTH-1:0] delta;

  // MOVE delta: sign-extend a narrow argument, or keep the low address
  // bits of a wide one; either way the add wraps modulo 2^A_WIDTH.
  if (A_WIDTH > D_WIDTH) begin : g_sext
    assign delta = {{(A_WIDTH-D_WIDTH){cmd_arg[D_WIDTH-1]}}, cmd_arg};
  end else begin : g_trunc
    assign delta = cmd_arg[A_WIDTH-1:0];
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rv_q;
  assign rsp_data  = rdata_q;
  assign rsp_zero  = (rdata_q == '0);
  assign ptr       = ptr_q;
  assign mem_rce   = rce_q;
  assign mem_ra    = ra_q;
  assign mem_wce   = wce_q;
  assign mem_wa    = wa_q;
  assign mem_wd    = wd_q;

  // Next-state logic: strobes default low so every RAM access is a
  // single-cycle pulse issued from exactly one state transition.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    arg_d    = arg_q;
    is_add_d = is_add_q;
    rce_d    = 1'b0;
    ra_d     = ra_q;
    wce_d    = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    rv_d     = rv_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_MOVE: ptr_d = ptr_q + delta;
            OP_WRITE: begin
              state_d = S_WR;
              wce_d   = 1'b1;
              wa_d    = ptr_q;
              wd_d    = cmd_arg;
            end
            OP_ADD, OP_READ: begin
              state_d  = S_RD;
              rce_d    = 1'b1;
              ra_d     = ptr_q;
              arg_d    = cmd_arg;
              is_add_d = (cmd_op == OP_ADD);
            end
          endcase
        end
      end
      // RAM samples the read strobe at the end of this cycle.
      S_RD: state_d = S_MOD;
      // Read data is on mem_rq now: either fold in the delta or latch it.
      S_MOD: begin
        if (is_add_q) begin
          state_d = S_WR;
          wce_d   = 1'b1;
          wa_d    = ptr_q;
          wd_d    = mem_rq + arg_q;
        end else begin
          state_d = S_RSP;
          rv_d    = 1'b1;
          rdata_d = mem_rq;
        end
      end
      S_WR: state_d = S_IDLE;
      S_RSP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      arg_q    <= '0;
      is_add_q <= 1'b0;
      rce_q    <= 1'b0;
      ra_q     <= '0;
      wce_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      arg_q    <= arg_d;
      is_add_q <= is_add_d;
      rce_q    <= rce_d;
      ra_q     <= ra_d;
      wce_q    <= wce_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
